// File: rtl/btb_update_ctrl_if.sv
// Update/write-port bundle between the ID stage, the BTB update controller and the BTB array.
interface btb_update_ctrl_if #(
  parameter int unsigned IDX_W = 4
);
  logic             flush;
  logic             upd_valid;
  logic             upd_ready;
  logic             upd_hit;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       upd_state;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic             port_busy;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [33:0]      wr_data;
  logic             wr_vld;
  logic [IDX_W-1:0] alloc_ptr;
  logic             busy;

  modport master (
    output flush, upd_valid, upd_hit, upd_idx, upd_state, upd_taken, upd_target, port_busy,
    input  upd_ready, wr_en, wr_idx, wr_data, wr_vld, alloc_ptr, busy
  );

  modport slave (
    input  flush, upd_valid, upd_hit, upd_idx, upd_state, upd_taken, upd_target, port_busy,
    output upd_ready, wr_en, wr_idx, wr_data, wr_vld, alloc_ptr, busy
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB update controller: queues resolved-branch updates, drains them into the BTB
// write port, and runs a full invalidate sweep after reset or flush.
module btb_update_ctrl #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned QDEPTH  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  btb_update_ctrl_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  typedef enum logic {SWEEP = 1'b0, RUN = 1'b1} state_e;

  typedef struct packed {
    logic             vld;
    logic [1:0]       st;
    logic [IDX_W-1:0] idx;
    logic [31:0]      target;
  } q_entry_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_idx_q;
  logic [IDX_W-1:0] alloc_q;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  q_entry_t         mem [QDEPTH];

  q_entry_t         head, new_entry;
  logic [1:0]       next_st;
  logic             full, empty, push, pop;
  logic             upd_ready, wr_en, wr_vld, busy;
  logic [IDX_W-1:0] wr_idx;
  logic [33:0]      wr_data;

  assign full  = (count_q == CNT_W'(QDEPTH));
  assign empty = (count_q == '0);
  assign head  = mem[rd_ptr_q];
  assign push  = bus.upd_valid && upd_ready;
  assign pop   = (state_q == RUN) && wr_en;

  // Saturating 2-bit counter, encoding 01 < 00 < 10 < 11 from strong-NT to strong-T
  always_comb begin
    next_st = 2'b00;
    if (!bus.upd_hit) begin
      next_st = {bus.upd_taken, 1'b0};
    end else begin
      unique case (bus.upd_state)
        2'b11: next_st = bus.upd_taken ? 2'b11 : 2'b10;
        2'b10: next_st = bus.upd_taken ? 2'b11 : 2'b00;
        2'b00: next_st = bus.upd_taken ? 2'b10 : 2'b01;
        2'b01: next_st = bus.upd_taken ? 2'b00 : 2'b01;
        default: next_st = 2'b00;
      endcase
    end
  end

  always_comb begin
    new_entry.vld    = 1'b1;
    new_entry.st     = next_st;
    new_entry.idx    = bus.upd_hit ? bus.upd_idx : alloc_q;
    new_entry.target = bus.upd_target;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= SWEEP;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SWEEP: if (!bus.flush && !bus.port_busy && sweep_idx_q == LAST_IDX) state_d = RUN;
      RUN:   if (bus.flush) state_d = SWEEP;
      default: state_d = SWEEP;
    endcase
  end

  // A flush in RUN suppresses the drain so no discarded entry reaches the array
  always_comb begin
    upd_ready = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = '0;
    wr_data   = '0;
    wr_vld    = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      SWEEP: begin
        busy   = 1'b1;
        wr_en  = !bus.port_busy;
        wr_idx = sweep_idx_q;
      end
      RUN: begin
        upd_ready = !full;
        wr_en     = !empty && !bus.port_busy && !bus.flush;
        wr_idx    = head.idx;
        wr_data   = {head.st, head.target};
        wr_vld    = head.vld;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sweep_idx_q <= '0;
      alloc_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      if (state_q == SWEEP) begin
        if (bus.flush) begin
          sweep_idx_q <= '0;
        end else if (wr_en) begin
          sweep_idx_q <= (sweep_idx_q == LAST_IDX) ? '0 : sweep_idx_q + IDX_W'(1);
          if (sweep_idx_q == LAST_IDX) alloc_q <= '0;
        end
      end else if (push && !bus.upd_hit) begin
        alloc_q <= (alloc_q == LAST_IDX) ? '0 : alloc_q + IDX_W'(1);
      end

      if (state_q == RUN && bus.flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_q <= count_q + CNT_W'(1);
        else if (pop && !push) count_q <= count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= new_entry;
  end

  assign bus.upd_ready = upd_ready;
  assign bus.wr_en     = wr_en;
  assign bus.wr_idx    = wr_idx;
  assign bus.wr_data   = wr_data;
  assign bus.wr_vld    = wr_vld;
  assign bus.alloc_ptr = alloc_q;
  assign bus.busy      = busy;
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: update vector table plus sweep, backpressure,
// wrap and flush sequences.
module tb_btb_update_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  btb_update_ctrl_if #(.IDX_W(4)) bus ();

  btb_update_ctrl #(.ENTRIES(16), .IDX_W(4), .QDEPTH(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        hit;
    logic [3:0]  idx;
    logic [1:0]  st;
    logic        taken;
    logic [31:0] target;
    logic [3:0]  exp_idx;
    logic [1:0]  exp_st;
    logic [3:0]  exp_alloc;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic hit, input logic [3:0] idx,
                       input logic [1:0] st, input logic taken, input logic [31:0] tgt);
    bus.upd_valid  = v;
    bus.upd_hit    = hit;
    bus.upd_idx    = idx;
    bus.upd_state  = st;
    bus.upd_taken  = taken;
    bus.upd_target = tgt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (16) tick();
  endtask

  initial begin
    tbl[0] = '{1'b0, 4'd0, 2'b00, 1'b1, 32'h0000_0040, 4'd0, 2'b10, 4'd1};
    tbl[1] = '{1'b1, 4'd3, 2'b11, 1'b0, 32'h0000_1000, 4'd3, 2'b10, 4'd1};
    tbl[2] = '{1'b1, 4'd3, 2'b01, 1'b1, 32'h0000_1004, 4'd3, 2'b00, 4'd1};
    tbl[3] = '{1'b1, 4'd3, 2'b11, 1'b1, 32'h0000_1008, 4'd3, 2'b11, 4'd1};
    tbl[4] = '{1'b1, 4'd7, 2'b10, 1'b1, 32'hDEAD_BEE0, 4'd7, 2'b11, 4'd1};
    tbl[5] = '{1'b1, 4'd7, 2'b10, 1'b0, 32'h0000_2000, 4'd7, 2'b00, 4'd1};
    tbl[6] = '{1'b1, 4'd9, 2'b00, 1'b1, 32'h0000_3000, 4'd9, 2'b10, 4'd1};
    tbl[7] = '{1'b1, 4'd9, 2'b00, 1'b0, 32'h0000_3004, 4'd9, 2'b01, 4'd1};
    tbl[8] = '{1'b1, 4'd15, 2'b01, 1'b0, 32'hFFFF_FFFC, 4'd15, 2'b01, 4'd1};
    tbl[9] = '{1'b0, 4'd5, 2'b11, 1'b0, 32'h0000_1234, 4'd1, 2'b00, 4'd2};

    rst = 1'b1;
    bus.flush = 1'b0;
    bus.port_busy = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 2'b00, 1'b0, 32'h0);
    tick();
    rst = 1'b0;

    // Power-on invalidate sweep
    chk("rst_busy", 64'(bus.busy), 64'd1);
    chk("rst_ready", 64'(bus.upd_ready), 64'd0);
    chk("rst_data", 64'(bus.wr_data), 64'd0);
    for (int k = 0; k < 16; k++) begin
      chk("sweep_en", 64'(bus.wr_en), 64'd1);
      chk("sweep_idx", 64'(bus.wr_idx), 64'(k));
      chk("sweep_vld", 64'(bus.wr_vld), 64'd0);
      tick();
    end
    chk("post_sweep_busy", 64'(bus.busy), 64'd0);
    chk("post_sweep_ready", 64'(bus.upd_ready), 64'd1);
    chk("post_sweep_alloc", 64'(bus.alloc_ptr), 64'd0);
    chk("post_sweep_wr_en", 64'(bus.wr_en), 64'd0);

    // Single updates through an empty queue
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, tbl[i].hit, tbl[i].idx, tbl[i].st, tbl[i].taken, tbl[i].target);
      #1;
      chk("tbl_ready", 64'(bus.upd_ready), 64'd1);
      chk("tbl_no_early_wr", 64'(bus.wr_en), 64'd0);
      tick();
      drive(1'b0, 1'b0, 4'd0, 2'b00, 1'b0, 32'h0);
      #1;
      chk("tbl_wr_en", 64'(bus.wr_en), 64'd1);
      chk("tbl_wr_idx", 64'(bus.wr_idx), 64'(tbl[i].exp_idx));
      chk("tbl_wr_data", 64'(bus.wr_data), 64'({tbl[i].exp_st, tbl[i].target}));
      chk("tbl_wr_vld", 64'(bus.wr_vld), 64'd1);
      chk("tbl_alloc", 64'(bus.alloc_ptr), 64'(tbl[i].exp_alloc));
      tick();
      chk("tbl_drained", 64'(bus.wr_en), 64'd0);
    end

    // Port busy: queue fills at four, then drains in order
    bus.port_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 4'(k + 1), 2'b00, 1'b1, 32'h100 + 32'(k));
      #1;
      chk("bp_ready", 64'(bus.upd_ready), (k < 4) ? 64'd1 : 64'd0);
      chk("bp_stall", 64'(bus.wr_en), 64'd0);
      tick();
    end
    drive(1'b0, 1'b0, 4'd0, 2'b00, 1'b0, 32'h0);
    bus.port_busy = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_wr_en", 64'(bus.wr_en), 64'd1);
      chk("bp_wr_idx", 64'(bus.wr_idx), 64'(k + 1));
      chk("bp_wr_data", 64'(bus.wr_data), 64'({2'b10, 32'h100 + 32'(k)}));
      tick();
    end
    chk("bp_empty", 64'(bus.wr_en), 64'd0);
    chk("bp_ready_back", 64'(bus.upd_ready), 64'd1);

    // Flush with two pending entries
    bus.port_busy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 4'd2, 2'b11, 1'b1, 32'h500 + 32'(k));
      tick();
    end
    drive(1'b0, 1'b0, 4'd0, 2'b00, 1'b0, 32'h0);
    bus.flush = 1'b1;
    bus.port_busy = 1'b0;
    #1;
    chk("flush_no_wr", 64'(bus.wr_en), 64'd0);
    chk("flush_alloc_before", 64'(bus.alloc_ptr), 64'd2);
    tick();
    bus.flush = 1'b0;
    #1;
    chk("flush_busy", 64'(bus.busy), 64'd1);
    chk("flush_ready", 64'(bus.upd_ready), 64'd0);
    for (int k = 0; k < 16; k++) begin
      if (k == 8) begin
        bus.port_busy = 1'b1;
        #1;
        chk("sweep_stall_en", 64'(bus.wr_en), 64'd0);
        chk("sweep_stall_idx", 64'(bus.wr_idx), 64'd8);
        tick();
        bus.port_busy = 1'b0;
        #1;
      end
      chk("fsweep_en", 64'(bus.wr_en), 64'd1);
      chk("fsweep_idx", 64'(bus.wr_idx), 64'(k));
      chk("fsweep_vld", 64'(bus.wr_vld), 64'd0);
      tick();
    end
    chk("fsweep_done", 64'(bus.busy), 64'd0);
    chk("fsweep_alloc", 64'(bus.alloc_ptr), 64'd0);
    chk("fsweep_discard", 64'(bus.wr_en), 64'd0);

    // Seventeen back-to-back misses: allocation wraps, push and pop overlap
    do_reset();
    for (int c = 0; c < 19; c++) begin
      drive(c < 17, 1'b0, 4'd0, 2'b00, 1'b1, 32'h1000 + 32'(c));
      #1;
      if (c < 17) chk("wrap_ready", 64'(bus.upd_ready), 64'd1);
      if (c >= 1 && c <= 17) begin
        chk("wrap_wr_en", 64'(bus.wr_en), 64'd1);
        chk("wrap_wr_idx", 64'(bus.wr_idx), 64'((c - 1) % 16));
        chk("wrap_wr_data", 64'(bus.wr_data), 64'({2'b10, 32'h1000 + 32'(c - 1)}));
      end
      if (c == 18) chk("wrap_drained", 64'(bus.wr_en), 64'd0);
      tick();
    end
    chk("wrap_alloc", 64'(bus.alloc_ptr), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/btb_update_ctrl.md
BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 Parameter ENTRIES, default 16, number of BTB entries.
REQ-002 Parameter IDX_W, default 4, BTB index width (log2 ENTRIES).
REQ-003 Parameter QDEPTH, default 4, update-queue depth (power of two).
REQ-004 i_clk  in  1  clock; all state updates on rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_flush  in  1  request full BTB invalidate sweep.
REQ-007 i_upd_valid  in  1  resolved branch update offered from ID stage.
REQ-008 o_upd_ready  out  1  update accepted when i_upd_valid && o_upd_ready at a rising edge.
REQ-009 i_upd_hit  in  1  branch already mapped to an entry.
REQ-010 i_upd_idx  in  IDX_W  index of the existing entry (used when hit).
REQ-011 i_upd_state  in  2  current 2-bit predictor state of that entry.
REQ-012 i_upd_taken  in  1  resolved direction.
REQ-013 i_upd_target  in  32  resolved target PC.
REQ-014 i_port_busy  in  1  BTB write port unavailable this cycle.
REQ-015 o_wr_en  out  1  BTB write strobe.
REQ-016 o_wr_idx  out  IDX_W  entry written.
REQ-017 o_wr_data  out  34  {state[1:0], target[31:0]}.
REQ-018 o_wr_vld  out  1  valid bit written to the entry.
REQ-019 o_alloc_ptr  out  IDX_W  next entry allocated for a new branch.
REQ-020 o_busy  out  1  high while the flush sweep is in progress.

Function
REQ-021 FSM states: SWEEP, RUN; SWEEP writes one entry per cycle; RUN drains the queue.
REQ-022 State encoding: 01 strong-NT, 00 weak-NT, 10 weak-T, 11 strong-T.
REQ-023 Hit update: next state = saturating move toward i_upd_taken (11->T 11/NT 10; 10->11/00; 00->10/01; 01->00/01); index = i_upd_idx.
REQ-024 Miss update: state = {i_upd_taken,1'b0}; index = o_alloc_ptr at enqueue; alloc pointer increments modulo ENTRIES at enqueue (15 wraps to 0).
REQ-025 Next state, index, target and vld=1 computed at enqueue and stored in the FIFO queue.
REQ-026 o_upd_ready = RUN && queue not full; a full queue does not accept a push even if a pop occurs in the same cycle.
REQ-027 In RUN: o_wr_en = queue non-empty && !i_port_busy (combinational); o_wr_* driven from queue head; head popped at the edge where o_wr_en=1.
REQ-028 Minimum latency: update accepted at edge N is written in the cycle following N.
REQ-029 Simultaneous push and pop on a non-full, non-empty queue: occupancy unchanged, order preserved.
REQ-030 i_port_busy stalls the drain indefinitely; queue contents are held.
REQ-031 i_flush high in RUN: queue emptied at the next edge, any pending entries discarded, state -> SWEEP, sweep index = 0.
REQ-032 SWEEP: o_wr_en = !i_port_busy, o_wr_idx = sweep index, o_wr_vld = 0, o_wr_data = 0; index advances only on a write; after index ENTRIES-1 is written -> RUN, alloc pointer = 0.
REQ-033 i_flush during SWEEP restarts the sweep at index 0.
REQ-034 o_busy = (state == SWEEP); o_upd_ready = 0 during SWEEP.

Reset
REQ-035 i_rst: state = SWEEP, sweep index 0, queue empty, alloc pointer 0; o_busy = 1, o_upd_ready = 0 in the cycle after reset.
REQ-036 Reset asserted mid-sweep or mid-drain overrides all other inputs and restarts the sweep from index 0.

Verification
REQ-037 Reset, i_port_busy=0 -> o_wr_en with vld=0 at idx 0..15 on 16 consecutive cycles, then o_busy=0, o_upd_ready=1, o_alloc_ptr=0.
REQ-038 Miss, taken, target 0x40 -> next cycle: write idx 0, data {10,0x40}, vld 1; o_alloc_ptr=1.
REQ-039 Hit, idx 3, state 11, not taken -> data state 10; state 01, taken -> 00; state 11, taken -> 11.
REQ-040 Hold i_port_busy=1, push 5 updates -> 4 accepted, o_upd_ready=0; release busy -> 4 writes in push order, 1 per cycle.
REQ-041 17 consecutive misses -> indices 0..15 then 0 (wrap).
REQ-042 Queue holds 2 entries, assert i_flush -> no queued write issued; 16-entry invalidate sweep follows; alloc pointer = 0.
